// File: rtl/lm75_temp_monitor_if.sv
// Sample/result bundle between the LM75 reader side and the temperature monitor.
// The master drives raw readings and consumes the monitor results.
interface lm75_temp_monitor_if;
  logic [15:0] temperature;
  logic        raw_valid;
  logic [15:0] avg_temp;
  logic        avg_valid;
  logic [15:0] last_temp;
  logic        alarm;
  logic        sample_error;
  logic        stale;

  modport master (
    output temperature, raw_valid,
    input  avg_temp, avg_valid, last_temp, alarm, sample_error, stale
  );

  modport slave (
    input  temperature, raw_valid,
    output avg_temp, avg_valid, last_temp, alarm, sample_error, stale
  );
endinterface

// File: rtl/lm75_temp_monitor.sv
// LM75 temperature monitor: range check, power-of-two moving average,
// over-temperature alarm with hysteresis and stale-data detection.
module lm75_temp_monitor #(
  parameter int        AVG_LOG2       = 2,
  parameter int signed T_HIGH         = 160,
  parameter int signed T_LOW          = 150,
  parameter int        TIMEOUT_CYCLES = 1000000
) (
  input logic clk,
  input logic rst,
  lm75_temp_monitor_if.slave bus
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 9 + AVG_LOG2;
  localparam int IW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic signed [8:0] tHigh  = 9'(T_HIGH);
  localparam logic signed [8:0] tLow   = 9'(T_LOW);
  localparam logic signed [8:0] minRaw = -9'sd110;
  localparam logic signed [8:0] maxRaw = 9'sd250;
  localparam logic [CW-1:0]     tMax   = CW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0]     idxMax = IW'(DEPTH - 1);

  logic signed [8:0]    rawSample;
  logic                 inRange;
  logic                 s1Valid;
  logic signed [8:0]    s1Sample;
  logic signed [8:0]    sampleBuf [DEPTH];
  logic [IW-1:0]        idx;
  logic                 primed;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] sumNext;
  logic signed [8:0]    avgNext;
  logic [CW-1:0]        idleCnt;

  assign rawSample = bus.temperature[15:7];
  assign inRange   = (rawSample >= minRaw) && (rawSample <= maxRaw);

  // The first accepted sample after reset fills the whole window so the
  // average starts at that value instead of ramping up from zero.
  always_comb begin
    sumNext = sum;
    if (primed)
      sumNext = sum - SW'(sampleBuf[idx]) + SW'(s1Sample);
    else
      sumNext = SW'(s1Sample) <<< AVG_LOG2;
    avgNext = 9'(sumNext >>> AVG_LOG2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid          <= 1'b0;
      s1Sample         <= '0;
      sum              <= '0;
      idx              <= '0;
      primed           <= 1'b0;
      for (int i = 0; i < DEPTH; i++) sampleBuf[i] <= '0;
      bus.avg_temp     <= '0;
      bus.avg_valid    <= 1'b0;
      bus.last_temp    <= '0;
      bus.alarm        <= 1'b0;
      bus.sample_error <= 1'b0;
    end else begin
      s1Valid  <= bus.raw_valid && inRange;
      s1Sample <= rawSample;
      if (bus.raw_valid && !inRange)
        bus.sample_error <= 1'b1;

      bus.avg_valid <= s1Valid;
      if (s1Valid) begin
        sum           <= sumNext;
        bus.last_temp <= 16'(s1Sample);
        bus.avg_temp  <= 16'(avgNext);
        if (primed) begin
          sampleBuf[idx] <= s1Sample;
          idx            <= (idx == idxMax) ? '0 : idx + IW'(1);
        end else begin
          for (int i = 0; i < DEPTH; i++) sampleBuf[i] <= s1Sample;
          primed <= 1'b1;
        end
        if (avgNext >= tHigh)
          bus.alarm <= 1'b1;
        else if (avgNext < tLow)
          bus.alarm <= 1'b0;
      end
    end
  end

  // Any strobe, accepted or rejected, proves the reader is alive.
  always_ff @(posedge clk) begin
    if (rst)
      idleCnt <= '0;
    else if (bus.raw_valid)
      idleCnt <= '0;
    else if (idleCnt != tMax)
      idleCnt <= idleCnt + CW'(1);
  end

  assign bus.stale = (idleCnt == tMax);

endmodule
